// File: rtl/ibex_icache_mem_resp_pkg.sv
// Shared types and helpers for the icache memory-side responder: the response
// entry layout, countdown width, data generator and region matcher.
package ibex_icache_mem_resp_pkg;

  // Countdown width covers every supported Latency (1..MaxLatency).
  localparam int unsigned MaxLatency = 16;
  localparam int unsigned CntW       = $clog2(MaxLatency);

  typedef struct packed {
    logic [29:0]     word_addr;
    logic            err;
    logic [CntW-1:0] cnt;
  } resp_entry_t;

  localparam int unsigned EntryW = $bits(resp_entry_t);

  function automatic logic [31:0] gen_rdata(input logic [31:0] addr, input logic [31:0] seed);
    return (addr & 32'hFFFF_FFFC) ^ seed;
  endfunction

  function automatic logic region_match(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ibex_icache_mem_resp_fifo.sv
// In-order response FIFO; every occupied entry counts down to zero so the head
// can be presented once its fixed latency has elapsed.
module ibex_icache_mem_resp_fifo
  import ibex_icache_mem_resp_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [EntryW-1:0] push_entry,
  input  logic              pop,
  output logic [EntryW-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned OccW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  resp_entry_t       mem [Depth];
  logic [Depth-1:0]  vld_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]   occ_q;

  assign full  = (occ_q == OccW'(Depth));
  assign empty = (occ_q == '0);
  assign head  = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      occ_q <= occ_q + OccW'(push) - OccW'(pop);
    end
  end

  // Entry storage is data only: validity lives in vld_q, so no reset here.
  for (genvar i = 0; i < Depth; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == PtrW'(i))) begin
        mem[i] <= resp_entry_t'(push_entry);
      end else if (vld_q[i] && (mem[i].cnt != '0)) begin
        mem[i].cnt <= mem[i].cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ibex_icache_mem_responder.sv
// Memory-side responder for the icache fetch interface: delayed grant, PMP
// rejection and fixed-latency in-order responses. Optional ERR/PMP regions are
// compiled in with IBEX_ICACHE_MEM_RESP_ERR_EN.
module ibex_icache_mem_responder
  import ibex_icache_mem_resp_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned GntDelay       = 1,
  parameter int unsigned Latency        = 2,
  parameter logic [31:0] Seed           = 32'hA5A5_0000,
  parameter logic [31:0] ErrBase        = 32'h8000_0000,
  parameter logic [31:0] ErrMask        = 32'hFFFF_0000,
  parameter logic [31:0] PmpBase        = 32'h9000_0000,
  parameter logic [31:0] PmpMask        = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        gnt,
  output logic        pmp_err,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned WaitW = (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(GntDelay);

  logic [WaitW-1:0] wait_q;
  logic             pmp_hit, err_hit, delay_ok;
  logic             full, empty, pop;
  resp_entry_t      push_entry, head;

`ifdef IBEX_ICACHE_MEM_RESP_ERR_EN
  assign pmp_hit = region_match(addr, PmpBase, PmpMask);
  assign err_hit = region_match(addr, ErrBase, ErrMask);
`else
  // Folds to 0; the region parameters stay referenced for a uniform interface.
  assign pmp_hit = 1'b0 & region_match(addr, PmpBase, PmpMask);
  assign err_hit = 1'b0 & region_match(addr, ErrBase, ErrMask);
`endif

  if (GntDelay == 0) begin : g_no_delay
    assign delay_ok = 1'b1;
  end else begin : g_delay
    assign delay_ok = (wait_q == WaitMax);
  end

  assign pmp_err = ~rst & req & pmp_hit;
  assign gnt     = ~rst & req & ~pmp_hit & delay_ok & ~full;

  always_ff @(posedge clk) begin
    if (rst || !req || gnt || pmp_err) begin
      wait_q <= '0;
    end else if (wait_q != WaitMax) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign push_entry = '{word_addr: addr[31:2], err: err_hit, cnt: CntW'(Latency - 1)};

  ibex_icache_mem_resp_fifo #(
    .Depth(MaxOutstanding)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (gnt),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // The icache never back-pressures, so a presented response retires at once.
  assign rvalid = ~rst & ~empty & (head.cnt == '0);
  assign pop    = rvalid;
  assign err    = rvalid & head.err;
  assign rdata  = (rvalid && !head.err) ? gen_rdata({head.word_addr, 2'b00}, Seed) : 32'h0;

endmodule

// File: tb/tb_ibex_icache_mem_responder.sv
// Bench for ibex_icache_mem_responder: three configurations checked every cycle
// against a queue-based response model, plus directed latency/region checks.
module tb_ibex_icache_mem_responder;

  localparam int NI = 3;
  localparam logic [31:0] Key = 32'hA5A5_0000;
`ifdef IBEX_ICACHE_MEM_RESP_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req     [NI];
  logic [31:0] addr    [NI];
  logic        gnt     [NI];
  logic        pmp_err [NI];
  logic        rvalid  [NI];
  logic [31:0] rdata   [NI];
  logic        err     [NI];

  always #5 clk = ~clk;

  ibex_icache_mem_responder u_def (
    .clk(clk), .rst(rst), .req(req[0]), .addr(addr[0]), .gnt(gnt[0]),
    .pmp_err(pmp_err[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .err(err[0]));

  ibex_icache_mem_responder #(.MaxOutstanding(2), .GntDelay(0), .Latency(1)) u_stream (
    .clk(clk), .rst(rst), .req(req[1]), .addr(addr[1]), .gnt(gnt[1]),
    .pmp_err(pmp_err[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .err(err[1]));

  ibex_icache_mem_responder #(.MaxOutstanding(2), .GntDelay(1), .Latency(4)) u_full (
    .clk(clk), .rst(rst), .req(req[2]), .addr(addr[2]), .gnt(gnt[2]),
    .pmp_err(pmp_err[2]), .rvalid(rvalid[2]), .rdata(rdata[2]), .err(err[2]));

  function automatic int mo(int k);  return (k == 0) ? 4 : 2; endfunction
  function automatic int gd(int k);  return (k == 1) ? 0 : 1; endfunction
  function automatic int lat(int k); return (k == 0) ? 2 : ((k == 1) ? 1 : 4); endfunction

  // Reference model: outstanding grants as (address, due cycle) queues.
  int          cyc;
  int          held [NI];
  logic [31:0] q_addr [NI][16];
  int          q_due  [NI][16];
  int          q_hd [NI];
  int          q_n  [NI];

  int          n_total, n_pass;
  logic        obs_gnt_now [NI];
  logic        obs_pmp_now [NI];
  int          obs_gnt_n [NI], obs_gnt_cyc [NI], obs_pmp_n [NI];
  int          obs_rv_n [NI], obs_rv_cyc [NI], obs_rv_first [NI];
  logic [31:0] obs_rdata [NI];
  logic        obs_err [NI];
  int          gcyc [3];
  int          c0;
  logic [31:0] rnd_addr;

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s inst%0d cyc%0d: got %h expected %h", tag, k, cyc, obs, exp);
  endtask

  task automatic clear_obs(int k);
    obs_gnt_n[k] = 0; obs_gnt_cyc[k] = -1000; obs_pmp_n[k] = 0;
    obs_rv_n[k] = 0; obs_rv_cyc[k] = -1000; obs_rv_first[k] = -1000;
    obs_rdata[k] = 32'hDEAD_BEEF; obs_err[k] = 1'b0;
  endtask

  task automatic eval(int k);
    logic e_pmp, e_gnt, e_rv, e_err;
    logic [31:0] e_rdata, ha;
    e_pmp = 1'b0; e_gnt = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_rdata = 32'h0; ha = 32'h0;
    obs_gnt_now[k] = gnt[k];
    obs_pmp_now[k] = pmp_err[k];
    if (gnt[k]) begin obs_gnt_n[k]++; obs_gnt_cyc[k] = cyc; end
    if (pmp_err[k]) obs_pmp_n[k]++;
    if (rvalid[k]) begin
      if (obs_rv_n[k] == 0) obs_rv_first[k] = cyc;
      obs_rv_n[k]++; obs_rv_cyc[k] = cyc; obs_rdata[k] = rdata[k]; obs_err[k] = err[k];
    end
    if (!rst) begin
      e_pmp = ErrEn && req[k] && (addr[k][31:16] == 16'h9000);
      e_gnt = req[k] && !e_pmp && (held[k] >= gd(k)) && (q_n[k] < mo(k));
      if (q_n[k] > 0 && q_due[k][q_hd[k]] == cyc) begin
        e_rv    = 1'b1;
        ha      = q_addr[k][q_hd[k]];
        e_err   = ErrEn && (ha[31:16] == 16'h8000);
        e_rdata = e_err ? 32'h0 : ({ha[31:2], 2'b00} ^ Key);
      end
    end
    chk("gnt", k, 32'(gnt[k]), 32'(e_gnt));
    chk("pmp_err", k, 32'(pmp_err[k]), 32'(e_pmp));
    chk("rvalid", k, 32'(rvalid[k]), 32'(e_rv));
    chk("rdata", k, rdata[k], e_rdata);
    chk("err", k, 32'(err[k]), 32'(e_err));
    if (rst) begin
      q_n[k] = 0; q_hd[k] = 0; held[k] = 0;
    end else begin
      if (e_rv) begin q_hd[k] = (q_hd[k] + 1) % 16; q_n[k]--; end
      if (e_gnt) begin
        int t;
        t = (q_hd[k] + q_n[k]) % 16;
        q_addr[k][t] = addr[k];
        q_due[k][t]  = cyc + lat(k);
        q_n[k]++;
      end
      held[k] = (req[k] && !e_gnt && !e_pmp) ? held[k] + 1 : 0;
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are checked on the falling edge.
  task automatic tick();
    #4;
    for (int k = 0; k < NI; k++) eval(k);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic single_fetch();
    clear_obs(0);
    c0 = cyc;
    req[0] = 1'b1; addr[0] = 32'h0000_1000;
    tick(); tick();
    req[0] = 1'b0;
    repeat (3) tick();
    chk("single_gnt_lat", 0, obs_gnt_cyc[0] - c0, 1);
    chk("single_rv_lat", 0, obs_rv_cyc[0] - obs_gnt_cyc[0], 2);
    chk("single_rdata", 0, obs_rdata[0], 32'hA5A5_1000);
    chk("single_err", 0, 32'(obs_err[0]), 0);
    chk("single_rv_n", 0, obs_rv_n[0], 1);
  endtask

  initial begin
    n_total = 0; n_pass = 0; cyc = 0; rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; addr[k] = 32'h0; held[k] = 0; q_n[k] = 0; q_hd[k] = 0;
      obs_gnt_now[k] = 1'b0; obs_pmp_now[k] = 1'b0;
      clear_obs(k);
    end
    @(posedge clk);
    #1;
    tick(); tick();
    rst = 1'b0;
    tick();

    single_fetch();

    // Streaming: one grant and one response per cycle.
    clear_obs(1);
    for (int i = 0; i < 8; i++) begin
      req[1] = 1'b1; addr[1] = 32'h100 + 32'(4 * i);
      tick();
    end
    req[1] = 1'b0;
    tick(); tick();
    chk("stream_gnts", 1, obs_gnt_n[1], 8);
    chk("stream_rvs", 1, obs_rv_n[1], 8);
    chk("stream_contig", 1, obs_rv_cyc[1] - obs_rv_first[1], 7);
    chk("stream_last_rdata", 1, obs_rdata[1], 32'hA5A5_011C);

    // Full FIFO: third grant waits for the first response.
    clear_obs(2);
    for (int i = 0; i < 3; i++) begin
      int n;
      req[2] = 1'b1; addr[2] = 32'h0000_2000 + 32'(16 * i);
      n = 0;
      do begin tick(); n++; end while (!obs_gnt_now[2] && n < 20);
      chk("full_gnt_bound", 2, 32'(obs_gnt_now[2]), 1);
      gcyc[i] = obs_gnt_cyc[2];
    end
    req[2] = 1'b0;
    repeat (6) tick();
    chk("full_third_gnt", 2, gcyc[2], obs_rv_first[2] + 1);
    chk("full_gap", 2, gcyc[2] - gcyc[0], 5);
    chk("full_rvs", 2, obs_rv_n[2], 3);

    // PMP region.
    clear_obs(0);
    req[0] = 1'b1; addr[0] = 32'h9000_0040;
    tick(); tick();
    req[0] = 1'b0;
    repeat (4) tick();
    chk("pmp_cycles", 0, obs_pmp_n[0], ErrEn ? 2 : 0);
    chk("pmp_gnts", 0, obs_gnt_n[0], ErrEn ? 0 : 1);
    chk("pmp_rvs", 0, obs_rv_n[0], ErrEn ? 0 : 1);

    // Bus-error region.
    clear_obs(0);
    req[0] = 1'b1; addr[0] = 32'h8000_0010;
    tick(); tick();
    req[0] = 1'b0;
    repeat (3) tick();
    chk("errrgn_rvs", 0, obs_rv_n[0], 1);
    chk("errrgn_err", 0, 32'(obs_err[0]), ErrEn ? 1 : 0);
    chk("errrgn_rdata", 0, obs_rdata[0], ErrEn ? 32'h0 : 32'h25A5_0010);

    // Reset with two responses outstanding.
    clear_obs(2);
    req[2] = 1'b1; addr[2] = 32'h0000_3000;
    tick(); tick();
    addr[2] = 32'h0000_3004;
    tick(); tick();
    req[2] = 1'b0;
    chk("rst_pre_gnts", 2, obs_gnt_n[2], 2);
    chk("rst_pre_rvs", 2, obs_rv_n[2], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_obs(2);
    repeat (8) tick();
    chk("rst_no_rv", 2, obs_rv_n[2], 0);
    single_fetch();

    // Randomized traffic; a waiting request keeps its address until answered.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (!(req[k] && !obs_gnt_now[k] && !obs_pmp_now[k])) begin
          req[k] = ($urandom_range(0, 2) != 0);
          rnd_addr = $urandom;
          case ($urandom_range(0, 3))
            0: rnd_addr[31:16] = 16'h8000;
            1: rnd_addr[31:16] = 16'h9000;
            default: ;
          endcase
          addr[k] = rnd_addr;
        end
      end
      tick();
    end
    for (int k = 0; k < NI; k++) req[k] = 1'b0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
